// File: rtl/uart_rx_if.sv
// Serial receive bundle: the line input plus the received-byte outputs.
// The receiver takes the slave side; whoever drives the line takes the master side.
interface uart_rx_if #(
   parameter int DW = 8
);
   logic          rx;
   logic [DW-1:0] rx_data;
   logic          rx_valid;
   logic          rx_frame_err;
   logic          rx_busy;

   modport master (
      output rx,
      input  rx_data, rx_valid, rx_frame_err, rx_busy
   );

   modport slave (
      input  rx,
      output rx_data, rx_valid, rx_frame_err, rx_busy
   );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 8N1-style framing, start bit sampled at half a bit, later bits one bit apart.
// Pulses rx_valid on a good stop bit and rx_frame_err on a low stop bit.
//
// state | meaning
// IDLE  | waiting for a falling edge on the synchronized line
// START | counting to mid start bit; a high sample rejects a glitch
// DATA  | sampling DW data bits, LSB first
// STOP  | sampling the stop bit, then pulsing valid or frame error
module uart_rx #(
   parameter int CLK_FREQ  = 100_000_000,
   parameter int BAUD_RATE = 115200,
   parameter int DW        = 8
) (
   input  logic      clk_i,
   input  logic      rst_n_i,
   uart_rx_if.slave  bus
);
   localparam int BAUD_COUNT = CLK_FREQ / BAUD_RATE;
   localparam int HALF       = BAUD_COUNT / 2;
   localparam int CW         = $clog2(BAUD_COUNT);
   localparam int BW         = $clog2(DW + 1);

   localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
   localparam logic [CW-1:0] BAUD_M1 = CW'(BAUD_COUNT - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DW - 1);

   localparam logic [3:0] S_IDLE  = 4'b0001;
   localparam logic [3:0] S_START = 4'b0010;
   localparam logic [3:0] S_DATA  = 4'b0100;
   localparam logic [3:0] S_STOP  = 4'b1000;

   logic          sync1_q, sync2_q, rx_prev_q;
   logic          rx_s;
   logic [3:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [BW-1:0] bit_q, bit_d;
   logic [DW-1:0] shift_q, shift_d;
   logic [DW-1:0] data_q, data_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;

   assign rx_s = sync2_q;

   // Synchronizer and edge-history flops reset high so reset release never looks like a start edge.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         sync1_q   <= bus.rx;
         sync2_q   <= sync1_q;
         rx_prev_q <= rx_s;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (rx_prev_q && !rx_s) begin
               state_d = S_START;
               cnt_d   = '0;
            end
         end
         S_START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = rx_s ? S_IDLE : S_DATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DATA: begin
            if (cnt_q == BAUD_M1) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[DW-1:1]};
               bit_d   = bit_q + BW'(1);
               if (bit_q == LAST_BIT) state_d = S_STOP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_STOP: begin
            if (cnt_q == BAUD_M1) begin
               cnt_d   = '0;
               state_d = S_IDLE;
               if (rx_s) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            bit_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   assign bus.rx_data      = data_q;
   assign bus.rx_valid     = valid_q;
   assign bus.rx_frame_err = ferr_q;
   assign bus.rx_busy      = state_q[1] | state_q[2] | state_q[3];
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, serial bit rate.
REQ-003 Parameter DW, default 8, data bits per frame.
REQ-004 clk_i  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-006 rx  input  1  asynchronous serial line; idle high.
REQ-007 rx_data  output  DW  last correctly framed byte, LSB received first.
REQ-008 rx_valid  output  1  one-cycle pulse: rx_data updated with a new frame.
REQ-009 rx_frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 rx_busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 BAUD_COUNT = CLK_FREQ/BAUD_RATE (integer divide); HALF = BAUD_COUNT/2; the baud counter SHALL be $clog2(BAUD_COUNT) bits wide.
REQ-012 rx SHALL pass through a 2-flop synchronizer, reset value 1; all FSM decisions SHALL use only the synchronized value (rx_s).
REQ-013 States SHALL be one-hot IDLE, START, DATA, STOP; illegal encodings SHALL return to IDLE on the next clock.
REQ-014 IDLE: a falling edge on rx_s (previous 1, current 0) -> START, baud counter cleared; a line held low does not trigger.
REQ-015 START: counter increments each clock; at counter==HALF-1 rx_s is sampled and the counter is cleared; 0 -> DATA, 1 -> IDLE (glitch rejected, no pulse on any output).
REQ-016 DATA: counter increments each clock; at counter==BAUD_COUNT-1 it SHALL sample rx_s, shift it in as shift_reg <= {rx_s, shift_reg[DW-1:1]}, clear the counter and increment the bit count.
REQ-017 After the DW-th data sample, DATA -> STOP.
REQ-018 STOP: at counter==BAUD_COUNT-1 rx_s is sampled, then the FSM goes to IDLE.
REQ-019 STOP sample 1: rx_data <= shift_reg and rx_valid = 1 for exactly the following clock.
REQ-020 STOP sample 0: rx_frame_err = 1 for exactly the following clock, and rx_data is left unchanged.
REQ-021 Sampling points SHALL fall mid-bit: the start bit is sampled HALF clocks after edge detect, and each later bit BAUD_COUNT clocks after the previous sample.
REQ-022 rx_valid SHALL rise (DW+1)*BAUD_COUNT+HALF+1 clocks after the edge-detect clock.
REQ-023 rx_valid and rx_frame_err SHALL never be high in the same cycle.
REQ-024 rx_data SHALL hold its value until the next valid frame. There is no overrun flag; the consumer must read within one frame time.
REQ-025 After a framing error, a new frame SHALL require rx_s to return high and then fall again (REQ-014).
REQ-026 rx_busy SHALL be combinational from the state: high in START, DATA and STOP.
REQ-027 Line activity during DATA or STOP SHALL affect only the samples; there SHALL be no resynchronization mid-frame.

Reset
REQ-028 On rst_n_i low, without waiting for a clock: state = IDLE, counters = 0, shift_reg = 0, synchronizer flops = 1.
REQ-029 Also on rst_n_i low: rx_data = 0, rx_valid = 0, rx_frame_err = 0, rx_busy = 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no pulse on rx_valid or rx_frame_err.
REQ-031 After release, the first frame SHALL be accepted only on a fresh falling edge.

Verification
REQ-032 Bench parameters SHALL be CLK_FREQ=1_000_000 and BAUD_RATE=100_000 (BAUD_COUNT=10, HALF=5), DW=8.
REQ-033 Frame 0xA5, stop bit 1 -> rx_data=0xA5, one rx_valid pulse at edge+96 clocks (REQ-022), rx_frame_err stays 0.
REQ-034 Back-to-back frames 0x00 then 0xFF, no idle gap -> two rx_valid pulses 100 clocks apart, with rx_data 0x00 then 0xFF.
REQ-035 Low glitch of 3 clocks on the idle line -> START then IDLE, rx_busy high for at most 6 clocks, no pulse on rx_valid or rx_frame_err.
REQ-036 Frame 0x3C with stop bit 0 -> one rx_frame_err pulse, rx_data keeps its prior value, and the next good frame 0x55 is received correctly.
REQ-037 rst_n_i low at data bit 4 of 0x81 -> outputs reset immediately, no pulse on any output, and a following frame 0x81 gives rx_data=0x81.
REQ-038 Loopback from the team's UART transmitter (same parameters) over 256 random bytes -> every byte is received exactly, with zero framing errors.
